// File: rtl/clk_period_meter_if.sv
// Port bundle for clk_period_meter: en/sig_in flow into the meter, measurements flow out.
// Valid/ready note: valid is a one-cycle strobe with no ready; consumers must capture period/high_time in that cycle.
interface clk_period_meter_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic [1:0]       state_dbg;

    modport master (
        output en,
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout,
        input  state_dbg
    );

    modport slave (
        input  en,
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output timeout,
        output state_dbg
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period of an asynchronous slow signal in clk cycles, with stall timeout.
// Optional macro CLK_METER_HIGH_EN adds high-phase measurement on high_time.
module clk_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    clk_period_meter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_d_q, sig_d_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   sig_s;
    logic                   rise;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    assign sig_s   = sync_q[SYNC_STAGES-1];
    assign sig_d_d = sig_s;
    assign rise    = sig_s & ~sig_d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!bus.en) begin
            // Disabling discards any partial measurement; results stay visible.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        cnt_d     = ONE;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MEASURE: begin
                    // A rise coinciding with cnt == TIMEOUT is a valid measurement, not a stall.
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        cnt_d     = ONE;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_EDGE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            sig_d_q   <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            sig_d_q   <= sig_d_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CLK_METER_HIGH_EN
    logic             fall;
    logic [WIDTH-1:0] hcap_q, hcap_d;
    logic [WIDTH-1:0] high_q, high_d;

    assign fall = ~sig_s & sig_d_q;

    // hcap survives a timeout; a fall always precedes the next accepted rise anyway.
    always_comb begin
        hcap_d = hcap_q;
        high_d = high_q;
        if (bus.en && state_q == MEASURE) begin
            if (rise) begin
                high_d = hcap_q;
            end else if (fall) begin
                hcap_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcap_q <= '0;
            high_q <= '0;
        end else begin
            hcap_q <= hcap_d;
            high_q <= high_d;
        end
    end

    assign bus.high_time = high_q;
`else
    assign bus.high_time = '0;
`endif

    assign bus.period    = period_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed scenarios then random waveforms,
// compared every cycle against a timestamp-based reference model.
module tb_clk_period_meter;
    localparam int W    = 32;
    localparam int SYNC = 2;
    localparam int TMO  = 100;
`ifdef CLK_METER_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    clk_period_meter_if #(.WIDTH(W)) bus ();

    clk_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timestamps of edges as seen after synchronization.
    logic hist[$];
    int   cyc;
    bit   enabled;
    bit   armed;
    int   anchor;
    int   hcap;
    int   exp_period;
    int   exp_high;
    bit   exp_valid;
    bit   exp_timeout;
    logic sig_lvl;
    int   phase_cnt;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + 1; i++) hist.push_back(1'b0);
        enabled     = 1'b0;
        armed       = 1'b0;
        anchor      = 0;
        hcap        = 0;
        exp_period  = 0;
        exp_high    = 0;
        exp_valid   = 1'b0;
        exp_timeout = 1'b0;
    endtask

    task automatic step(input logic en_v, input logic sig_v);
        logic s, sd, rise, fall;
        bus.en     = en_v;
        bus.sig_in = sig_v;
        @(posedge clk);
        cyc++;
        hist.push_back(sig_v);
        s    = hist[hist.size() - 1 - SYNC];
        sd   = hist[hist.size() - 2 - SYNC];
        hist.delete(0);
        rise = s & ~sd;
        fall = ~s & sd;
        exp_valid = 1'b0;
        if (!en_v) begin
            enabled = 1'b0;
        end else if (!enabled) begin
            enabled = 1'b1;
            armed   = 1'b0;
            anchor  = cyc + 1;
        end else if (rise) begin
            if (armed) begin
                exp_period = cyc - anchor;
                exp_high   = HIGH_EN ? hcap : 0;
                exp_valid  = 1'b1;
            end
            exp_timeout = 1'b0;
            armed       = 1'b1;
            anchor      = cyc;
        end else begin
            if (fall && armed) hcap = cyc - anchor;
            if (cyc - anchor == TMO) begin
                exp_timeout = 1'b1;
                armed       = 1'b0;
                anchor      = cyc + 1;
            end
        end
        #1;
        check("valid", W'(bus.valid), W'(exp_valid));
        check("period", bus.period, W'(exp_period));
        check("high_time", bus.high_time, W'(exp_high));
        check("timeout", W'(bus.timeout), W'(exp_timeout));
    endtask

    task automatic wave(input int half, input int n_cycles, input logic en_v);
        for (int i = 0; i < n_cycles; i++) begin
            if (phase_cnt >= half) begin
                sig_lvl   = ~sig_lvl;
                phase_cnt = 0;
            end
            phase_cnt++;
            step(en_v, sig_lvl);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sig_lvl    = ~sig_lvl;
            bus.sig_in = sig_lvl;
            @(posedge clk);
            #1;
            check("rst_period", bus.period, '0);
            check("rst_high_time", bus.high_time, '0);
            check("rst_valid", W'(bus.valid), '0);
            check("rst_timeout", W'(bus.timeout), '0);
        end
        rst = 1'b0;
        phase_cnt = 0;
        model_reset();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        sig_lvl    = 1'b0;
        phase_cnt  = 0;
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        rst        = 1'b1;
        model_reset();
        #2;

        // 1: reset with sig_in toggling, then no valid while disabled
        do_reset();
        wave(4, 20, 1'b0);

        // 2: divider n = 4
        wave(4, 64, 1'b1);
        check("t2_period", bus.period, W'(8));
        check("t2_high", bus.high_time, HIGH_EN ? W'(4) : W'(0));

        // 3: divider n = 1
        wave(1, 20, 1'b1);
        check("t3_period", bus.period, W'(2));
        check("t3_high", bus.high_time, HIGH_EN ? W'(1) : W'(0));

        // 4: stall then resume
        wave(4, 40, 1'b1);
        sig_lvl   = 1'b0;
        phase_cnt = 0;
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0);
        check("t4_timeout_set", W'(bus.timeout), W'(1));
        check("t4_period_held", bus.period, W'(8));
        wave(4, 40, 1'b1);
        check("t4_timeout_clr", W'(bus.timeout), W'(0));
        check("t4_period", bus.period, W'(8));

        // 5: rise spacing exactly TIMEOUT
        wave(50, 400, 1'b1);
        check("t5_period", bus.period, W'(TMO));
        check("t5_timeout", W'(bus.timeout), W'(0));

        // 6: disable / reset mid-measurement
        wave(4, 40, 1'b1);
        check("t6_period_pre", bus.period, W'(8));
        wave(4, 3, 1'b1);
        wave(4, 20, 1'b0);
        check("t6_period_held", bus.period, W'(8));
        wave(4, 40, 1'b1);
        check("t6_period_reen", bus.period, W'(8));
        wave(4, 5, 1'b1);
        do_reset();
        wave(4, 40, 1'b1);
        check("t6_period_after_rst", bus.period, W'(8));

        // random waveforms with occasional disable and stalls
        for (int k = 0; k < 40; k++) begin
            wave($urandom_range(1, 60), $urandom_range(20, 150), ($urandom_range(0, 7) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
